tcu_responder: RTL and testbench
================================

# tcu_responder

Execution-side endpoint of the legacy TCU request/response handshake. It accepts one operation per `tcu_enable` assertion, drops `tcu_ready` as acknowledgement, and executes with per-class multi-cycle latency. DIV/MOD use a bit-serial divider. It returns a one-cycle `tcu_valid` (or `tcu_error`) pulse, then re-arms only after the initiator releases `tcu_enable`. It sits inside the CPU core behind the microcode-side TCU adapter and replaces the stub TCU.

## Interface
Parameters:
- WIDTH, `` `VTX1_WORD_WIDTH ``: operand/result width; operands are unsigned binary.
- LAT_SIMPLE, 2: cycles for ADD/SUB/MIN/MAX; must be ≥1.
- LAT_MAC, 4: cycles for MAC; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tcu_enable  in  1  request strobe; held high by the initiator until after the ack.
- tcu_operation  in  4  opcode; sampled at accept.
- tcu_operand_a / tcu_operand_b / tcu_operand_c  in  WIDTH each  operands; sampled at accept.
- tcu_result  out  WIDTH  result; registered.
- tcu_valid  out  1  one-cycle success pulse.
- tcu_ready  out  1  high when able to accept.
- tcu_error  out  1  one-cycle failure pulse.
- responder_state  out  3  current FSM state.
- completed_count  out  32  successful operations.
- error_count  out  32  failed operations.

## Operation
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 MAC: a*b+c.
  - 3 DIV: a/b.
  - 4 MOD: a%b.
  - 5 MIN: unsigned.
  - 6 MAX: unsigned.
  - 7–F: illegal.
- Arithmetic is modulo 2^WIDTH: ADD/SUB wrap; MAC keeps the low WIDTH bits of the full product plus c.
- FSM states: IDLE=0, EXEC=1, RESP=2, FAIL=3, RELEASE=4.
- IDLE:
  - `tcu_ready`=1.
  - On a sampled `tcu_enable`=1: latch opcode and operands, load the latency counter, set ready←0, go to EXEC.
  - Illegal opcode, or DIV/MOD with b=0: go to FAIL instead.
- EXEC:
  - Count down L cycles. L is LAT_SIMPLE, LAT_MAC, or WIDTH for DIV/MOD, where WIDTH is the divider iteration count.
  - At terminal count go to RESP.
  - `tcu_enable` is ignored in EXEC.
- RESP:
  - `tcu_valid`=1 for exactly this cycle; `tcu_result` is loaded on entry.
  - completed_count+1 (wraps at 2^32); go to RELEASE.
- FAIL:
  - `tcu_error`=1 for exactly this cycle; `tcu_valid`=0; `tcu_result` is loaded with 0.
  - error_count+1 (wraps); go to RELEASE.
- RELEASE:
  - ready stays 0 until `tcu_enable` is sampled 0.
  - Then go to IDLE; ready=1 from the next cycle.
  - An enable held high never causes a second accept.
- `tcu_valid` and `tcu_error` are never high together.
- `tcu_result` holds its last value until the next RESP or FAIL.

## Timing
- Reset values: `tcu_ready`=1; `tcu_valid`=0; `tcu_error`=0; `tcu_result`=0; `responder_state`=IDLE; both counters=0.
- Let E be the edge at which IDLE samples `tcu_enable`=1.
- `tcu_ready` falls after E.
- The valid pulse occupies the cycle after edge E+L+1.
- A FAIL pulse occupies the cycle after E+1.
- Minimum accept-to-accept spacing: L+3 cycles, plus however long `tcu_enable` stays high.
- Reset asserted mid-operation: the divider is abandoned and all outputs return to reset values asynchronously. No pulse is emitted after reset release.

## Structure
- Opcode constants (TCU_OP_*) go in `ternary_constants.v`.
- Responder state encodings (VTX1_TR_STATE_*) and default latency constants go in `vtx1_state_constants.v`.
- One sub-module: `tcu_serial_divider`.
  - Restoring, one quotient bit per cycle, WIDTH cycles.
  - Ports: start, dividend, divisor, busy, done, quotient, remainder.
  - Started at accept; its done aligns with the EXEC terminal count.

## Test plan
- ADD a=5, b=7, enable held 3 cycles → ready low after E; valid for one cycle after E+3; result=12; completed_count=1; ready returns 1 two cycles after enable low.
- SUB a=3, b=5 → result=2^WIDTH−2; MAC a=6, b=7, c=8 → result=50, valid after E+5.
- DIV a=100, b=7 → result=14; MOD same operands → result=2; each valid exactly WIDTH+1 cycles after E.
- DIV b=0, then opcode 0x9 → error pulses one cycle after E+1; valid stays 0; result=0; error_count=2; completed_count unchanged.
- Enable held high 20 cycles across completion → exactly one valid pulse; ready stays 0 until enable falls; no second accept.
- rst_n pulsed low mid-DIV → ready=1, valid=0, error=0, state=IDLE, counters=0 immediately; a subsequent ADD 1+1 → result=2.

Source files
------------

// File: rtl/tcu_responder_pkg.sv
// rtl/tcu_responder_pkg.sv - TCU responder opcodes, state encodings and default latencies
package tcu_responder_pkg;

  localparam int VTX1_WORD_WIDTH    = 16;
  localparam int VTX1_TR_LAT_SIMPLE = 2;
  localparam int VTX1_TR_LAT_MAC    = 4;

  typedef enum logic [3:0] {
    TCU_OP_ADD = 4'h0,
    TCU_OP_SUB = 4'h1,
    TCU_OP_MAC = 4'h2,
    TCU_OP_DIV = 4'h3,
    TCU_OP_MOD = 4'h4,
    TCU_OP_MIN = 4'h5,
    TCU_OP_MAX = 4'h6
  } tcu_op_e;

  typedef enum logic [2:0] {
    VTX1_TR_STATE_IDLE    = 3'd0,
    VTX1_TR_STATE_EXEC    = 3'd1,
    VTX1_TR_STATE_RESP    = 3'd2,
    VTX1_TR_STATE_FAIL    = 3'd3,
    VTX1_TR_STATE_RELEASE = 3'd4
  } tr_state_e;

  function automatic logic tcu_op_legal(input logic [3:0] op);
    return op <= TCU_OP_MAX;
  endfunction

  function automatic logic tcu_op_is_div(input logic [3:0] op);
    return (op == TCU_OP_DIV) || (op == TCU_OP_MOD);
  endfunction

endpackage

// File: rtl/tcu_serial_divider.sv
// rtl/tcu_serial_divider.sv - restoring bit-serial unsigned divider, one quotient bit per cycle
module tcu_serial_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[WIDTH]) begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Iteration registers; the quotient shifts in where the dividend shifts out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy      = (cnt_q != '0);
  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/tcu_responder.sv
// rtl/tcu_responder.sv - TCU request/response endpoint with per-class multi-cycle latency
module tcu_responder
  import tcu_responder_pkg::*;
#(
  parameter int WIDTH      = VTX1_WORD_WIDTH,
  parameter int LAT_SIMPLE = VTX1_TR_LAT_SIMPLE,
  parameter int LAT_MAC    = VTX1_TR_LAT_MAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tcu_enable,
  input  logic [3:0]       tcu_operation,
  input  logic [WIDTH-1:0] tcu_operand_a,
  input  logic [WIDTH-1:0] tcu_operand_b,
  input  logic [WIDTH-1:0] tcu_operand_c,
  output logic [WIDTH-1:0] tcu_result,
  output logic             tcu_valid,
  output logic             tcu_ready,
  output logic             tcu_error,
  output logic [2:0]       responder_state,
  output logic [31:0]      completed_count,
  output logic [31:0]      error_count
);

  localparam int CNT_W = 16;

  tr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [WIDTH-1:0] result_q, op_result;
  logic             valid_q, error_q;
  logic [31:0]      completed_q, errors_q;
  logic             accept, div_start;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  tcu_serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (tcu_operand_a),
    .divisor   (tcu_operand_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Next-state: accept, count down the latency, pulse, then wait for enable release
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      VTX1_TR_STATE_IDLE: begin
        if (tcu_enable) begin
          accept = 1'b1;
          if (!tcu_op_legal(tcu_operation) ||
              (tcu_op_is_div(tcu_operation) && tcu_operand_b == '0)) begin
            state_d = VTX1_TR_STATE_FAIL;
          end else begin
            state_d   = VTX1_TR_STATE_EXEC;
            div_start = tcu_op_is_div(tcu_operation);
            if (tcu_operation == TCU_OP_MAC) cnt_d = CNT_W'(LAT_MAC);
            else if (div_start)              cnt_d = CNT_W'(WIDTH);
            else                             cnt_d = CNT_W'(LAT_SIMPLE);
          end
        end
      end
      VTX1_TR_STATE_EXEC: begin
        if (tcu_op_is_div(op_q)) begin
          if (div_done || !div_busy) state_d = VTX1_TR_STATE_RESP;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = VTX1_TR_STATE_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      VTX1_TR_STATE_RESP:    state_d = VTX1_TR_STATE_RELEASE;
      VTX1_TR_STATE_FAIL:    state_d = VTX1_TR_STATE_RELEASE;
      VTX1_TR_STATE_RELEASE: if (!tcu_enable) state_d = VTX1_TR_STATE_IDLE;
      default:               state_d = VTX1_TR_STATE_IDLE;
    endcase
  end

  // Operation result from the latched operands; products keep the low WIDTH bits
  always_comb begin
    op_result = '0;
    case (op_q)
      TCU_OP_ADD: op_result = a_q + b_q;
      TCU_OP_SUB: op_result = a_q - b_q;
      TCU_OP_MAC: op_result = a_q * b_q + c_q;
      TCU_OP_DIV: op_result = div_quo;
      TCU_OP_MOD: op_result = div_rem;
      TCU_OP_MIN: op_result = (a_q < b_q) ? a_q : b_q;
      TCU_OP_MAX: op_result = (a_q > b_q) ? a_q : b_q;
      default:    op_result = '0;
    endcase
  end

  // State, operand latch, registered pulses, result and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= VTX1_TR_STATE_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      completed_q <= '0;
      errors_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_q == VTX1_TR_STATE_RESP);
      error_q <= (state_q == VTX1_TR_STATE_FAIL);
      if (accept) begin
        op_q <= tcu_operation;
        a_q  <= tcu_operand_a;
        b_q  <= tcu_operand_b;
        c_q  <= tcu_operand_c;
      end
      if (state_q == VTX1_TR_STATE_RESP) begin
        result_q    <= op_result;
        completed_q <= completed_q + 32'd1;
      end
      if (state_q == VTX1_TR_STATE_FAIL) begin
        result_q <= '0;
        errors_q <= errors_q + 32'd1;
      end
    end
  end

  assign tcu_result      = result_q;
  assign tcu_valid       = valid_q;
  assign tcu_error       = error_q;
  assign tcu_ready       = (state_q == VTX1_TR_STATE_IDLE);
  assign responder_state = state_q;
  assign completed_count = completed_q;
  assign error_count     = errors_q;

endmodule

// File: tb/tb_tcu_responder.sv
// tb/tb_tcu_responder.sv - self-checking bench for tcu_responder
module tb_tcu_responder;

  localparam int W      = 16;
  localparam int L_SIMP = 2;
  localparam int L_MAC  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tcu_enable = 1'b0;
  logic [3:0]   tcu_operation = 4'h0;
  logic [W-1:0] tcu_operand_a = '0;
  logic [W-1:0] tcu_operand_b = '0;
  logic [W-1:0] tcu_operand_c = '0;
  logic [W-1:0] tcu_result;
  logic         tcu_valid, tcu_ready, tcu_error;
  logic [2:0]   responder_state;
  logic [31:0]  completed_count, error_count;

  int n_checks = 0;
  int n_fail   = 0;

  tcu_responder #(.WIDTH(W), .LAT_SIMPLE(L_SIMP), .LAT_MAC(L_MAC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tcu_enable      (tcu_enable),
    .tcu_operation   (tcu_operation),
    .tcu_operand_a   (tcu_operand_a),
    .tcu_operand_b   (tcu_operand_b),
    .tcu_operand_c   (tcu_operand_c),
    .tcu_result      (tcu_result),
    .tcu_valid       (tcu_valid),
    .tcu_ready       (tcu_ready),
    .tcu_error       (tcu_error),
    .responder_state (responder_state),
    .completed_count (completed_count),
    .error_count     (error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour expressed as arithmetic and edge timing rules
  function automatic logic [W-1:0] model_calc(input logic [3:0] op, input logic [W-1:0] x,
                                              input logic [W-1:0] y, input logic [W-1:0] z);
    longint unsigned p;
    logic [W-1:0] r;
    case (op)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: begin p = longint'(x) * longint'(y) + longint'(z); r = W'(p); end
      4'd3: r = x / y;
      4'd4: r = x % y;
      4'd5: r = (x < y) ? x : y;
      4'd6: r = (x > y) ? x : y;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    if (op == 4'd2) return L_MAC;
    if (op == 4'd3 || op == 4'd4) return W;
    return L_SIMP;
  endfunction

  function automatic bit model_err(input logic [3:0] op, input logic [W-1:0] y);
    return (op > 4'd6) || ((op == 4'd3 || op == 4'd4) && y == '0);
  endfunction

  int           edge_n;
  int           m_pulse_edge;
  bit           m_idle, m_valid, m_error, m_err;
  logic [W-1:0] m_res, m_result;
  logic [31:0]  m_cc, m_ec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n <= 0; m_pulse_edge <= 0; m_idle <= 1'b1; m_valid <= 1'b0; m_error <= 1'b0;
      m_err <= 1'b0; m_res <= '0; m_result <= '0; m_cc <= '0; m_ec <= '0;
    end else begin
      edge_n  <= edge_n + 1;
      m_valid <= 1'b0;
      m_error <= 1'b0;
      if (m_idle) begin
        if (tcu_enable) begin
          m_idle <= 1'b0;
          m_err  <= model_err(tcu_operation, tcu_operand_b);
          m_res  <= model_calc(tcu_operation, tcu_operand_a, tcu_operand_b, tcu_operand_c);
          m_pulse_edge <= edge_n + (model_err(tcu_operation, tcu_operand_b) ? 1
                                    : model_lat(tcu_operation) + 1);
        end
      end else begin
        if (edge_n == m_pulse_edge) begin
          m_valid  <= !m_err;
          m_error  <= m_err;
          m_result <= m_err ? '0 : m_res;
          if (m_err) m_ec <= m_ec + 1;
          else       m_cc <= m_cc + 1;
        end
        if (edge_n > m_pulse_edge && !tcu_enable) m_idle <= 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", tcu_ready, m_idle);
      check("valid", tcu_valid, m_valid);
      check("error", tcu_error, m_error);
      check("result", tcu_result, m_result);
      check("completed_count", completed_count, m_cc);
      check("error_count", error_count, m_ec);
      if (m_idle) check("idle_state", responder_state, 3'd0);
    end
  end

  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] z, input int hold,
                        input logic [W-1:0] exp_res, input bit exp_err,
                        input int exp_pulse_i, input int exp_gap);
    int pulse_i = -1;
    int drop_i  = -1;
    int ready_i = -1;
    int pulses  = 0;
    @(negedge clk);
    tcu_operation = op; tcu_operand_a = x; tcu_operand_b = y; tcu_operand_c = z;
    tcu_enable = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (tcu_valid || tcu_error) begin
        pulses++;
        if (pulse_i < 0) begin
          pulse_i = i;
          check({nm, " lit_valid"}, tcu_valid, !exp_err);
          check({nm, " lit_error"}, tcu_error, exp_err);
          check({nm, " lit_result"}, tcu_result, exp_res);
        end
      end
      if (i == hold) begin
        tcu_enable = 1'b0;
        drop_i = i;
      end
      if (drop_i >= 0 && i > drop_i && pulse_i >= 0 && tcu_ready) begin
        ready_i = i;
        break;
      end
    end
    check({nm, " completes_in_budget"}, ready_i >= 0, 1);
    check({nm, " pulse_latency"}, pulse_i, exp_pulse_i);
    check({nm, " pulse_count"}, pulses, 1);
    if (exp_gap > 0) check({nm, " ready_after_release"}, ready_i - drop_i, exp_gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst ready", tcu_ready, 1);
    check("rst valid", tcu_valid, 0);
    check("rst error", tcu_error, 0);
    check("rst result", tcu_result, 0);
    check("rst state", responder_state, 0);
    check("rst completed", completed_count, 0);
    check("rst errors", error_count, 0);
    #2 rst_n = 1'b1;

    run_op("ADD", 4'd0, 16'd5,   16'd7,  16'd0, 3,  16'd12,   1'b0, 4, 2);
    check("ADD completed", completed_count, 1);
    run_op("SUB", 4'd1, 16'd3,   16'd5,  16'd0, 2,  16'hFFFE, 1'b0, 4, 0);
    run_op("MAC", 4'd2, 16'd6,   16'd7,  16'd8, 2,  16'd50,   1'b0, 6, 0);
    run_op("DIV", 4'd3, 16'd100, 16'd7,  16'd0, 2,  16'd14,   1'b0, W + 2, 0);
    run_op("MOD", 4'd4, 16'd100, 16'd7,  16'd0, 2,  16'd2,    1'b0, W + 2, 0);
    check("after MOD completed", completed_count, 5);
    run_op("DIV0", 4'd3, 16'd5,  16'd0,  16'd0, 1,  16'd0,    1'b1, 2, 0);
    run_op("OP9",  4'd9, 16'd5,  16'd3,  16'd0, 1,  16'd0,    1'b1, 2, 0);
    check("errors error_count", error_count, 2);
    check("errors completed", completed_count, 5);
    run_op("MAXHOLD", 4'd6, 16'd9, 16'd300, 16'd0, 20, 16'd300, 1'b0, 4, 1);
    check("hold completed", completed_count, 6);

    @(negedge clk);
    tcu_operation = 4'd3; tcu_operand_a = 16'd1000; tcu_operand_b = 16'd3;
    tcu_enable = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    tcu_enable = 1'b0;
    #1;
    check("midrst ready", tcu_ready, 1);
    check("midrst valid", tcu_valid, 0);
    check("midrst error", tcu_error, 0);
    check("midrst state", responder_state, 0);
    check("midrst result", tcu_result, 0);
    check("midrst completed", completed_count, 0);
    check("midrst errors", error_count, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op("ADD11", 4'd0, 16'd1, 16'd1, 16'd0, 2, 16'd2, 1'b0, 4, 0);
    check("post reset completed", completed_count, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
